// File: rtl/reg_file_sb.sv
// Two-write / two-read register file with same-cycle write bypass and a
// per-register pending-write scoreboard feeding the decode-stage hazard unit.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_wa,
  output logic              busy1,
  output logic              busy2,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef logic [DEPTH-1:0] vec_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DATA_W-1:0] rf [DEPTH];
  vec_t              busy;

  // Effective (qualified) write and issue strobes after register-0 filtering.
  logic wr1, wr2, iss;
  vec_t set_vec, clr_vec, busy_next;
  logic inc, dec1, dec2;
  cnt_t pend_cnt_next;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign wr1 = we1 && !is_zero(wa1);
  assign wr2 = we2 && !is_zero(wa2);
  assign iss = iss_en && !is_zero(iss_wa);

  // Read port 1: port 2 write data beats port 1, which beats the array.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rd1 = rf[ra1];
    if (is_zero(ra1)) begin
      rd1 = '0;
    end else if (wr2 && wa2 == ra1) begin
      rd1 = wd2;
    end else if (wr1 && wa1 == ra1) begin
      rd1 = wd1;
    end
  end

  always_comb begin
    rd2 = rf[ra2];
    if (is_zero(ra2)) begin
      rd2 = '0;
    end else if (wr2 && wa2 == ra2) begin
      rd2 = wd2;
    end else if (wr1 && wa1 == ra2) begin
      rd2 = wd1;
    end
  end

  // A writeback landing this cycle makes the bypassed operand usable now.
  assign busy1 = busy[ra1] && !((wr1 && wa1 == ra1) || (wr2 && wa2 == ra1));
  assign busy2 = busy[ra2] && !((wr1 && wa1 == ra2) || (wr2 && wa2 == ra2));

  // Issue sets after writeback clears: the newer producer keeps the bit.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss) set_vec = vec_t'(1) << iss_wa;
    if (wr1) clr_vec = clr_vec | (vec_t'(1) << wa1);
    if (wr2) clr_vec = clr_vec | (vec_t'(1) << wa2);
    busy_next = set_vec | (busy & ~clr_vec);
  end

  // Net population change; a shared wa1/wa2 clears at most one bit.
  always_comb begin
    inc  = iss && !busy[iss_wa];
    dec1 = wr1 && busy[wa1] && !(iss && iss_wa == wa1);
    dec2 = wr2 && busy[wa2] && !(iss && iss_wa == wa2) && !(wr1 && wa1 == wa2);
    pend_cnt_next = pend_cnt + cnt_t'(inc) - cnt_t'(dec1) - cnt_t'(dec2);
  end

  // NOTE: the array is reset along with the control state because a cleared
  // register file is architecturally visible; this rules out a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr1) rf[wa1] <= wd1;
      if (wr2) rf[wa2] <= wd2;
      busy     <= busy_next;
      pend_cnt <= pend_cnt_next;
    end
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised two-write / two-read register file with write-through bypass, synchronous clear and a per-register pending-write scoreboard. It sits in the decode stage of the pipelined CPU and replaces the single-write-port register file. Writeback from the ALU path (port 1) and the load path (port 2) lands here, and decode reads operands here. Busy flags tell the hazard unit whether an operand still has an in-flight producer.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- ZERO_REG, 1, when 1 register 0 is hardwired to zero; when 0 it is an ordinary register
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers and all busy bits
- we1  in  1  write enable, port 1 (ALU writeback)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- we2  in  1  write enable, port 2 (load writeback)
- wa2  in  ADDR_W  write address, port 2
- wd2  in  DATA_W  write data, port 2
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data, combinational
- iss_en  in  1  an instruction with a destination register issues this cycle
- iss_wa  in  ADDR_W  destination of the issuing instruction
- busy1, busy2  out  1  ra1 / ra2 has a pending producer (combinational)
- pend_cnt  out  ADDR_W+1  number of registers currently marked busy

## Operation
- **Storage:** 2**ADDR_W × DATA_W array plus a 2**ADDR_W-bit busy vector.
- **Writes:** on the rising edge, when we1 is set, rf[wa1] <= wd1; when we2 is set, rf[wa2] <= wd2.
  - If both ports write the same address in the same cycle, port 2 wins.
- **Reads:** rdN = rf[raN] by default, overridden by the write bypass below.
- **Write bypass:** a same-cycle write to raN is forwarded to rdN.
  - Priority: port 2 data, then port 1 data, then array contents.
- **Register 0 (ZERO_REG=1):**
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0, with no bypass.
  - Issue to address 0 is ignored, and busy for address 0 is always 0.
- **Scoreboard:**
  - Busy bit clear: writeback (we1 or we2) to address a clears busy[a] on the edge.
  - Busy bit set: iss_en sets busy[iss_wa] on the edge.
  - Issue and writeback to the same address in the same cycle: set wins, because a newer producer exists.
  - Writeback to a non-busy address is legal; the bit stays 0.
  - Issue to an already-busy address is legal; the bit stays 1. No per-register producer counting is done.
- **busyN:**
  - busyN = busy[raN] AND NOT (a same-cycle writeback to raN).
  - The bypassed value is valid, so no stall is needed.
  - A same-cycle issue does not affect busyN.
- **pend_cnt:**
  - Registered population count of the busy vector.
  - Updated each edge by applying the net change: +1 per bit going 0→1, −1 per bit going 1→0. Up to +1 and −2 per cycle.
  - Always equals popcount(busy). It cannot overflow because width is ADDR_W+1.
- **Reset:**
  - Synchronous reset clears every rf entry to 0, clears all busy bits, and sets pend_cnt to 0.
  - Writes and issues presented in the reset cycle are ignored.

## Timing
- Read latency 0: rd1/rd2/busy1/busy2 are combinational from ra*, wa*, we*, wd* and state.
- Write latency 1: data is visible in the array on the cycle after the edge, and visible via bypass in the same cycle.
- Issue → busy visible on busyN the cycle after iss_en.
- Writeback → busy clear: busyN drops in the writeback cycle (through the bypass term), and the stored bit clears on the edge.
- pend_cnt is valid one cycle after any issue or writeback.
- Reset outputs, in the cycle following a reset edge:
  - rd1 = rd2 = 0 unless a write is bypassed.
  - busy1 = busy2 = 0.
  - pend_cnt = 0.
- Reset asserted mid-operation discards all pending busy state. In-flight writebacks arriving after reset are treated as writes to non-busy registers.

## Test plan
- **Reset:** assert reset for 1 cycle after random writes → all 32 registers read 0, pend_cnt=0, busy1=busy2=0.
- **Write/bypass:** we1 wa1=5 wd1=0xDEADBEEF with ra1=5 in the same cycle → rd1=0xDEADBEEF in that cycle and after.
- **Port collision:** same cycle, we1 wa1=7 wd1=0x11 and we2 wa2=7 wd2=0x22, with ra2=7 → rd2=0x22 in that cycle, rf[7]=0x22 afterwards.
- **Zero register:** we2 wa2=0 wd2=0xFFFF_FFFF, then iss_en iss_wa=0 → rd1(ra1=0)=0, busy1=0, pend_cnt unchanged.
- **Scoreboard:**
  - Issue 3, then 9 → pend_cnt=2, and busy1=1 for ra1=3.
  - Writeback to 3 with ra1=3 → busy1=0 in that cycle, pend_cnt=1 next cycle.
  - Simultaneous iss_wa=9 and we1 wa1=9 → busy[9] stays 1, pend_cnt=1.
- **Double clear:** two busy regs 4 and 6, with we1 wa1=4 and we2 wa2=6 in the same cycle plus issue 8 → pend_cnt goes 2→1 next cycle.
